// File: rtl/move_buffer_writer.sv
// Producer side of the move-buffer toggle handshake: fills a ring of move slots,
// publishes each by flipping its stepready bit, and frees slots on move_done toggles.

module move_buffer_slot #(
    parameter int move_duration_bits = 32,
    parameter int increment_bits     = 64
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          wr_en,
    input  logic                          fin_en,
    input  logic [move_duration_bits-1:0] wr_duration,
    input  logic [increment_bits-1:0]     wr_increment,
    output logic [move_duration_bits-1:0] duration,
    output logic [increment_bits-1:0]     increment,
    output logic                          stepready,
    output logic                          slotfinished
);

    // Data and publish toggle change on the same edge so the consumer never
    // observes a flipped stepready bit alongside stale payload.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            duration     <= '0;
            increment    <= '0;
            stepready    <= 1'b0;
            slotfinished <= 1'b0;
        end else begin
            if (wr_en) begin
                duration  <= wr_duration;
                increment <= wr_increment;
                stepready <= ~stepready;
            end
            if (fin_en)
                slotfinished <= ~slotfinished;
        end
    end

endmodule

module move_buffer_writer #(
    parameter int buffer_bits        = 2,
    parameter int buffer_size        = 4,   // must equal 2**buffer_bits
    parameter int move_duration_bits = 32,
    parameter int increment_bits     = 64
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [move_duration_bits-1:0] cmd_duration,
    input  logic [increment_bits-1:0]     cmd_increment,
    input  logic [buffer_bits-1:0]        moveind,
    input  logic                          move_done,
    output logic [buffer_size-1:0]        stepready,
    output logic [move_duration_bits-1:0] move_duration,
    output logic [increment_bits-1:0]     increment,
    output logic [buffer_bits-1:0]        writeind,
    output logic [buffer_bits:0]          occupancy,
    output logic                          buffer_full,
    output logic                          buffer_empty,
    output logic                          protocol_err
);

    logic [buffer_bits-1:0]                         readind;
    logic                                           move_done_r;
    logic [buffer_size-1:0]                         slotfinished;
    logic [buffer_size-1:0][move_duration_bits-1:0] slot_duration;
    logic [buffer_size-1:0][increment_bits-1:0]     slot_increment;

    logic accept;
    logic done_evt;
    logic done_ok;

    assign buffer_full  = (occupancy == (buffer_bits+1)'(buffer_size));
    assign buffer_empty = (occupancy == '0);
    assign cmd_ready    = ~buffer_full;
    assign accept       = cmd_valid & cmd_ready;
    assign done_evt     = move_done ^ move_done_r;
    assign done_ok      = done_evt & ~buffer_empty;

    for (genvar g = 0; g < buffer_size; g++) begin : g_slot
        move_buffer_slot #(
            .move_duration_bits(move_duration_bits),
            .increment_bits    (increment_bits)
        ) u_slot (
            .clk         (clk),
            .resetn      (resetn),
            .wr_en       (accept  && (writeind == buffer_bits'(g))),
            .fin_en      (done_ok && (readind  == buffer_bits'(g))),
            .wr_duration (cmd_duration),
            .wr_increment(cmd_increment),
            .duration    (slot_duration[g]),
            .increment   (slot_increment[g]),
            .stepready   (stepready[g]),
            .slotfinished(slotfinished[g])
        );
    end

    assign move_duration = slot_duration[moveind];
    assign increment     = slot_increment[moveind];

    // Indices wrap naturally because buffer_size is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            writeind     <= '0;
            readind      <= '0;
            occupancy    <= '0;
            move_done_r  <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            move_done_r <= move_done;
            if (accept)
                writeind <= writeind + buffer_bits'(1);
            if (done_ok)
                readind <= readind + buffer_bits'(1);
            if (done_evt && buffer_empty)
                protocol_err <= 1'b1;
            case ({accept, done_ok})
                2'b10:   occupancy <= occupancy + (buffer_bits+1)'(1);
                2'b01:   occupancy <= occupancy - (buffer_bits+1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule
